// File: rtl/axis_fifo_pkg.sv
// Shared AXI-Stream definitions: the default beat type and the FIFO pointer-width helper.
package axis_fifo_pkg;

    localparam int AXIS_TDATA_WIDTH_DEFAULT = 32;

    typedef logic [AXIS_TDATA_WIDTH_DEFAULT-1:0] axis_beat_t;

    // One extra pointer bit beyond the index distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage: single write port, asynchronous read port, contents never reset.
module axis_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the accepted beat at the write index.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with wrap-bit pointers, synchronous flush and async reset.
// Optional zero-latency bypass when empty is enabled by defining AXIS_FIFO_FALLTHROUGH_EN.
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH = $bits(axis_beat_t),
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sif_tvalid,
    input  logic [TDATA_WIDTH-1:0]     sif_tdata,
    output logic                       sif_tready,
    output logic                       mif_tvalid,
    output logic [TDATA_WIDTH-1:0]     mif_tdata,
    input  logic                       mif_tready,
    input  logic                       invalidate,
    output logic [ptr_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic                   empty_s;
    logic                   full_s;
    logic                   stored_valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic [TDATA_WIDTH-1:0] rd_data_s;

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                        (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]);
    assign sif_tready = !full_s && !invalidate;
    assign count      = wr_ptr_r - rd_ptr_r;

    assign stored_valid_s = !empty_s && !invalidate;
    // Only a stored beat advances the read pointer; a bypassed beat never enters storage.
    assign pop_s          = stored_valid_s && mif_tready;

    // Output selection and push qualification, including the optional empty-FIFO bypass.
    always_comb begin
        mif_tvalid = stored_valid_s;
        mif_tdata  = rd_data_s;
        push_s     = sif_tvalid && sif_tready;
`ifdef AXIS_FIFO_FALLTHROUGH_EN
        if (empty_s && sif_tvalid && !invalidate) begin
            mif_tvalid = 1'b1;
            mif_tdata  = sif_tdata;
            push_s     = sif_tready && !mif_tready;
        end else begin
            mif_tvalid = stored_valid_s;
            mif_tdata  = rd_data_s;
        end
`endif
    end

    // Pointer state: async reset, synchronous flush, otherwise advance on handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (invalidate) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    axis_fifo_mem #(
        .WIDTH (TDATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (sif_tdata),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (rd_data_s)
    );

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, meaning tdata bit width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; legal values are powers of two >= 2.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port sif_tvalid  input  1  upstream beat valid.
REQ-006 SHALL have port sif_tdata  input  TDATA_WIDTH  upstream beat data.
REQ-007 SHALL have port sif_tready  output  1  FIFO can accept a beat.
REQ-008 SHALL have port mif_tvalid  output  1  FIFO presents a beat.
REQ-009 SHALL have port mif_tdata  output  TDATA_WIDTH  presented beat data.
REQ-010 SHALL have port mif_tready  input  1  downstream accepts the beat.
REQ-011 SHALL have port invalidate  input  1  synchronous flush of all stored beats.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored beats.

Function
REQ-013 SHALL use write/read pointers of $clog2(DEPTH)+1 bits; low bits index storage; MSB is the wrap bit; both increment modulo 2*DEPTH.
REQ-014 SHALL define empty as pointers equal and full as equal low bits with differing MSB.
REQ-015 SHALL drive sif_tready = !full && !invalidate, with no combinational path from mif_tready.
REQ-016 SHALL accept a push on sif_tvalid && sif_tready: write sif_tdata at the write pointer, then increment it.
REQ-017 SHALL drive mif_tvalid = !empty && !invalidate, and mif_tdata = storage[read pointer low bits].
REQ-018 SHALL pop on mif_tvalid && mif_tready by incrementing the read pointer.
REQ-019 SHALL hold mif_tdata stable while mif_tvalid && !mif_tready.
REQ-020 SHALL, on simultaneous push and pop with the FIFO neither empty nor full, perform both; count is unchanged.
REQ-021 SHALL refuse a push when full, even when a pop occurs in the same cycle; the freed slot is visible next cycle.
REQ-022 SHALL give a first-word latency of 1 cycle: a beat pushed into an empty FIFO appears on mif_tvalid the next cycle.
REQ-023 SHALL drive count = write pointer minus read pointer, modulo 2*DEPTH; count == DEPTH when full.
REQ-024 SHALL, when invalidate=1, set both pointers to 0 at the next edge; same-cycle push and pop are both suppressed, and storage contents are not cleared.
REQ-025 SHALL treat invalidate held for multiple cycles as repeated flushes; normal operation resumes the cycle after deassertion.

Reset
REQ-026 SHALL, on rst asserted, set both pointers to 0 immediately, independent of clk.
REQ-027 SHALL produce these output values under reset: sif_tready=1, mif_tvalid=0, count=0; mif_tdata is don't-care.
REQ-028 SHALL leave storage unreset; reset mid-operation discards all beats.

Configuration
REQ-029 SHALL use macro AXIS_FIFO_FALLTHROUGH_EN.
REQ-030 SHALL, with AXIS_FIFO_FALLTHROUGH_EN defined, when empty and sif_tvalid && !invalidate: drive mif_tvalid=1 and mif_tdata=sif_tdata combinationally.
REQ-031 SHALL, in that fall-through case, not store the beat if mif_tready=1 in the same cycle (zero latency).
REQ-032 SHALL, without AXIS_FIFO_FALLTHROUGH_EN, behave per REQ-022 with no combinational sif-to-mif path.

Structure
REQ-033 SHALL obtain the pointer-width helper (clog2 of DEPTH plus 1) and the shared axis beat typedef from the common axis package.
REQ-034 SHALL place storage in one sub-module, axis_fifo_mem: a 1-write, 1-async-read register array with no reset.

Verification
REQ-035 SHALL test fill and drain: DEPTH=4, mif_tready=0, push 0x11,0x22,0x33,0x44 -> sif_tready=0 after the 4th push, count=4; raise mif_tready -> 0x11..0x44 out in order, count returns to 0.
REQ-036 SHALL test streaming: sif_tvalid=1 and mif_tready=1 continuously with data 0..15 -> one beat per cycle after 1-cycle latency, no loss, count stays 1, pointers wrap twice.
REQ-037 SHALL test full with pop: FIFO full, push 0x55 while popping -> 0x55 refused that cycle, accepted next cycle, count=4 again.
REQ-038 SHALL test invalidate: 3 beats stored, invalidate pulsed for 1 cycle with a concurrent push of 0x99 -> next cycle mif_tvalid=0, count=0; 0x99 never emerges.
REQ-039 SHALL test async reset: rst asserted between clock edges with 2 beats stored -> mif_tvalid=0, count=0 before the next edge.
REQ-040 SHALL test fall-through with AXIS_FIFO_FALLTHROUGH_EN defined: empty FIFO, push 0xAB with mif_tready=1 -> mif_tdata=0xAB in the same cycle, count stays 0.
